// File: rtl/ddr_line_fetch.sv
// rtl/ddr_line_fetch.sv - Line fetcher: DDR burst reads streamed into the HDMI pixel FIFO
module ddr_line_fetch #(
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_WORDS    = 16,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  go_fill_fifo,
    input  logic [31:0]           ddr_addr_to_read,
    input  logic [15:0]           num_words,
    output logic                  mst_rd_req,
    output logic [31:0]           mst_addr,
    output logic [4:0]            mst_burst_len,
    input  logic                  mst_cmd_ack,
    input  logic [DATA_WIDTH-1:0] mst_rd_data,
    input  logic                  mst_rd_valid,
    input  logic                  fifo_space_ok,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  busy,
    output logic                  fetch_done,
    output logic                  req_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_REQ,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [4:0]  MAX_LEN   = 5'(BURST_WORDS);
    localparam logic [15:0] MAX_WORDS = 16'(BURST_WORDS);
    localparam logic [31:0] WORD_STEP = 32'(BYTES_PER_WORD);

    state_t                state_q, state_d;
    logic [31:0]           cur_addr_q, cur_addr_d;
    logic [15:0]           words_left_q, words_left_d;
    logic [4:0]            beats_left_q, beats_left_d;
    logic [4:0]            burst_len_q, burst_len_d;
    logic                  mst_rd_req_q, mst_rd_req_d;
    logic [31:0]           mst_addr_q, mst_addr_d;
    logic [4:0]            mst_burst_len_q, mst_burst_len_d;
    logic                  fifo_wr_en_q, fifo_wr_en_d;
    logic [DATA_WIDTH-1:0] fifo_wr_data_q, fifo_wr_data_d;
    logic                  busy_q, busy_d;
    logic                  fetch_done_q, fetch_done_d;
    logic                  req_overrun_q, req_overrun_d;
    logic [4:0]            next_len;

    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        words_left_d    = words_left_q;
        beats_left_d    = beats_left_q;
        burst_len_d     = burst_len_q;
        mst_rd_req_d    = mst_rd_req_q;
        mst_addr_d      = mst_addr_q;
        mst_burst_len_d = mst_burst_len_q;
        fifo_wr_en_d    = 1'b0;
        fifo_wr_data_d  = fifo_wr_data_q;
        busy_d          = busy_q;
        fetch_done_d    = 1'b0;
        next_len        = (words_left_q >= MAX_WORDS) ? MAX_LEN : words_left_q[4:0];
        // A request arriving while busy (DONE included) is dropped and flagged.
        req_overrun_d   = go_fill_fifo && busy_q;

        case (state_q)
            S_IDLE: begin
                if (go_fill_fifo) begin
                    cur_addr_d   = ddr_addr_to_read;
                    words_left_d = num_words;
                    busy_d       = 1'b1;
                    state_d      = (num_words == 16'd0) ? S_DONE : S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (fifo_space_ok) begin
                    burst_len_d     = next_len;
                    mst_addr_d      = cur_addr_q;
                    mst_burst_len_d = next_len;
                    mst_rd_req_d    = 1'b1;
                    state_d         = S_REQ;
                end
            end
            S_REQ: begin
                if (mst_cmd_ack) begin
                    mst_rd_req_d = 1'b0;
                    beats_left_d = burst_len_q;
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (mst_rd_valid) begin
                    fifo_wr_en_d   = 1'b1;
                    fifo_wr_data_d = mst_rd_data;
                    beats_left_d   = beats_left_q - 5'd1;
                    words_left_d   = words_left_q - 16'd1;
                    if (beats_left_q == 5'd1) begin
                        cur_addr_d = cur_addr_q + {27'd0, burst_len_q} * WORD_STEP;
                        state_d    = (words_left_q == 16'd1) ? S_DONE : S_WAIT_SPACE;
                    end
                end
            end
            S_DONE: begin
                fetch_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            cur_addr_q      <= 32'd0;
            words_left_q    <= 16'd0;
            beats_left_q    <= 5'd0;
            burst_len_q     <= 5'd0;
            mst_rd_req_q    <= 1'b0;
            mst_addr_q      <= 32'd0;
            mst_burst_len_q <= 5'd0;
            fifo_wr_en_q    <= 1'b0;
            fifo_wr_data_q  <= '0;
            busy_q          <= 1'b0;
            fetch_done_q    <= 1'b0;
            req_overrun_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            words_left_q    <= words_left_d;
            beats_left_q    <= beats_left_d;
            burst_len_q     <= burst_len_d;
            mst_rd_req_q    <= mst_rd_req_d;
            mst_addr_q      <= mst_addr_d;
            mst_burst_len_q <= mst_burst_len_d;
            fifo_wr_en_q    <= fifo_wr_en_d;
            fifo_wr_data_q  <= fifo_wr_data_d;
            busy_q          <= busy_d;
            fetch_done_q    <= fetch_done_d;
            req_overrun_q   <= req_overrun_d;
        end
    end

    assign mst_rd_req    = mst_rd_req_q;
    assign mst_addr      = mst_addr_q;
    assign mst_burst_len = mst_burst_len_q;
    assign fifo_wr_en    = fifo_wr_en_q;
    assign fifo_wr_data  = fifo_wr_data_q;
    assign busy          = busy_q;
    assign fetch_done    = fetch_done_q;
    assign req_overrun   = req_overrun_q;

endmodule

// File: tb/tb_ddr_line_fetch.sv
// tb/tb_ddr_line_fetch.sv - Randomised bench for ddr_line_fetch against a fetch-level model
module tb_ddr_line_fetch;

    localparam longint NEVER = 64'sh7FFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        reset_n;
    logic        go_fill_fifo;
    logic [31:0] ddr_addr_to_read;
    logic [15:0] num_words;
    logic        mst_rd_req;
    logic [31:0] mst_addr;
    logic [4:0]  mst_burst_len;
    logic        mst_cmd_ack;
    logic [31:0] mst_rd_data;
    logic        mst_rd_valid;
    logic        fifo_space_ok;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        busy;
    logic        fetch_done;
    logic        req_overrun;

    ddr_line_fetch #(
        .DATA_WIDTH    (32),
        .BURST_WORDS   (16),
        .BYTES_PER_WORD(4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .go_fill_fifo    (go_fill_fifo),
        .ddr_addr_to_read(ddr_addr_to_read),
        .num_words       (num_words),
        .mst_rd_req      (mst_rd_req),
        .mst_addr        (mst_addr),
        .mst_burst_len   (mst_burst_len),
        .mst_cmd_ack     (mst_cmd_ack),
        .mst_rd_data     (mst_rd_data),
        .mst_rd_valid    (mst_rd_valid),
        .fifo_space_ok   (fifo_space_ok),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_wr_data    (fifo_wr_data),
        .busy            (busy),
        .fetch_done      (fetch_done),
        .req_overrun     (req_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks;
    int          errors;
    int          wr_count;
    int          ovr_count;
    longint      cyc;
    logic [31:0] exp_data[$];
    logic [31:0] exp_req_addr[$];
    int          exp_req_len[$];
    logic [31:0] obs_addr[$];
    int          obs_len[$];

    logic [31:0] t2_addr[5] = '{32'hA8000000, 32'hA8000040, 32'hA8000080, 32'hA80000C0, 32'hA8000100};
    int          t2_len[5]  = '{16, 16, 16, 16, 5};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fetch-level model: each accepted go expands into its burst list and word count.
    initial begin
        bit          m_active;
        longint      m_go, m_done_due, m_ovr_due;
        int          m_words_left;
        bit          exp_busy;
        bit          prev_req, prev_ack, prev_space;
        logic [31:0] prev_addr;
        logic [4:0]  prev_len;
        logic [31:0] a;
        int          rem, l;
        bit          wr_ok;
        m_active = 0; m_go = 0; m_done_due = NEVER; m_ovr_due = NEVER; m_words_left = 0;
        prev_req = 0; prev_ack = 0; prev_space = 0; prev_addr = 0; prev_len = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                check("reset_outputs", {mst_rd_req, mst_addr, mst_burst_len, fifo_wr_en, fifo_wr_data,
                                        busy, fetch_done, req_overrun}, 128'd0);
                m_active = 0; m_done_due = NEVER; m_ovr_due = NEVER; m_words_left = 0;
                exp_data.delete(); exp_req_addr.delete(); exp_req_len.delete();
                prev_req = 0; prev_ack = 0; prev_space = 0;
            end else begin
                exp_busy = m_active && (cyc > m_go) && (cyc < m_done_due);
                check("busy", busy, exp_busy);
                check("fetch_done", fetch_done, m_active && (cyc == m_done_due));
                check("req_overrun", req_overrun, cyc == m_ovr_due);
                if (req_overrun) ovr_count++;

                if (mst_rd_req) begin
                    if (prev_req && !prev_ack) begin
                        check("req_hold_addr", mst_addr, prev_addr);
                        check("req_hold_len", mst_burst_len, prev_len);
                    end else begin
                        check("req_after_space", prev_space, 1);
                        check("req_expected", exp_req_addr.size() != 0, 1);
                        if (exp_req_addr.size() != 0) begin
                            check("req_addr", mst_addr, exp_req_addr.pop_front());
                            check("req_len", mst_burst_len, exp_req_len.pop_front());
                        end
                    end
                end

                if (fifo_wr_en) begin
                    wr_count++;
                    wr_ok = (exp_data.size() != 0) && (m_words_left > 0);
                    check("wr_expected", wr_ok, 1);
                    if (wr_ok) begin
                        check("wr_data", fifo_wr_data, exp_data.pop_front());
                        m_words_left--;
                        if (m_words_left == 0) m_done_due = cyc + 1;
                    end
                end

                if (m_active && cyc == m_done_due) begin
                    check("all_reqs_issued", exp_req_addr.size(), 0);
                    check("all_data_written", exp_data.size(), 0);
                    m_active = 0;
                    m_done_due = NEVER;
                end

                if (go_fill_fifo) begin
                    if (exp_busy) begin
                        m_ovr_due = cyc + 1;
                    end else begin
                        m_active = 1;
                        m_go = cyc;
                        m_words_left = int'(num_words);
                        m_done_due = (num_words == 16'd0) ? cyc + 2 : NEVER;
                        a = ddr_addr_to_read;
                        rem = int'(num_words);
                        while (rem > 0) begin
                            l = (rem > 16) ? 16 : rem;
                            exp_req_addr.push_back(a);
                            exp_req_len.push_back(l);
                            a = a + 32'(l * 4);
                            rem -= l;
                        end
                    end
                end

                prev_req   = mst_rd_req;
                prev_ack   = mst_cmd_ack;
                prev_space = fifo_space_ok;
                prev_addr  = mst_addr;
                prev_len   = mst_burst_len;
            end
        end
    end

    task automatic run_fetch(input logic [31:0] a, input int n, input bit bp, input bit ovr);
        int remaining, len, k;
        obs_addr.delete();
        obs_len.delete();
        @(posedge clk); #1;
        go_fill_fifo = 1; ddr_addr_to_read = a; num_words = 16'(n);
        @(posedge clk); #1;
        go_fill_fifo = 0;
        remaining = n;
        while (remaining > 0) begin
            k = 0;
            while (!mst_rd_req && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            check("req_timeout", mst_rd_req, 1);
            if (!mst_rd_req) return;
            len = int'(mst_burst_len);
            obs_addr.push_back(mst_addr);
            obs_len.push_back(len);
            // Stray beats before the command is accepted must never reach the FIFO.
            repeat ($urandom_range(0, 3)) begin
                mst_rd_valid = 1'($urandom_range(0, 1));
                mst_rd_data = $urandom;
                @(posedge clk); #1;
            end
            mst_rd_valid = 0;
            mst_cmd_ack = 1;
            @(posedge clk); #1;
            mst_cmd_ack = 0;
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                mst_rd_valid = 1;
                mst_rd_data = $urandom;
                exp_data.push_back(mst_rd_data);
                if (ovr && b == 3) begin
                    go_fill_fifo = 1;
                    ddr_addr_to_read = $urandom;
                    num_words = 16'($urandom_range(1, 100));
                end
                if (bp && b == len - 1 && remaining > len) fifo_space_ok = 0;
                @(posedge clk); #1;
                mst_rd_valid = 0;
                go_fill_fifo = 0;
            end
            remaining -= len;
            if (bp && remaining > 0) begin
                for (int i = 0; i < 19; i++) begin
                    check("bp_no_req", mst_rd_req, 0);
                    @(posedge clk); #1;
                end
                fifo_space_ok = 1;
                @(posedge clk); #1;
                check("bp_resume", mst_rd_req, 1);
            end
        end
        k = 0;
        while (!fetch_done && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_timeout", fetch_done, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, n;
        logic [31:0] a;
        checks = 0; errors = 0; wr_count = 0; ovr_count = 0; cyc = 0;
        reset_n = 0; go_fill_fifo = 0; ddr_addr_to_read = 0; num_words = 0;
        mst_cmd_ack = 0; mst_rd_data = 0; mst_rd_valid = 0; fifo_space_ok = 1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        // Single full burst
        wr_count = 0;
        run_fetch(32'hA8000000, 16, 0, 0);
        check("t1_nreq", obs_addr.size(), 1);
        check("t1_addr", obs_addr[0], 32'hA8000000);
        check("t1_len", obs_len[0], 16);
        check("t1_writes", wr_count, 16);
        check("t1_busy_after", busy, 0);

        // Multi-burst with a partial tail
        wr_count = 0;
        run_fetch(32'hA8000000, 69, 0, 0);
        check("t2_nreq", obs_addr.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_addr", obs_addr[i], t2_addr[i]);
            check("t2_len", obs_len[i], t2_len[i]);
        end
        check("t2_writes", wr_count, 69);

        // Backpressure between bursts
        wr_count = 0;
        run_fetch(32'h10000000, 48, 1, 0);
        check("t3_nreq", obs_addr.size(), 3);
        check("t3_writes", wr_count, 48);

        // Zero length, plus a go landing in DONE
        ovr_count = 0;
        @(posedge clk); #1;
        go_fill_fifo = 1; ddr_addr_to_read = 32'h12345678; num_words = 16'd0;
        @(posedge clk); #1;
        check("z_busy_1", busy, 1);
        check("z_done_1", fetch_done, 0);
        num_words = 16'd5;
        @(posedge clk); #1;
        go_fill_fifo = 0;
        check("z_done_2", fetch_done, 1);
        check("z_busy_2", busy, 0);
        check("z_overrun_2", req_overrun, 1);
        @(posedge clk); #1;
        check("z_done_3", fetch_done, 0);
        check("z_noreq", mst_rd_req, 0);
        check("z_ovr_count", ovr_count, 1);

        // Overrun during a fetch
        wr_count = 0; ovr_count = 0;
        run_fetch(32'h40000000, 16, 0, 1);
        check("t5_overrun", ovr_count, 1);
        check("t5_writes", wr_count, 16);

        // Address wrap
        run_fetch(32'hFFFFFFC0, 32, 0, 0);
        check("t6_nreq", obs_addr.size(), 2);
        check("t6_addr0", obs_addr[0], 32'hFFFFFFC0);
        check("t6_addr1", obs_addr[1], 32'h00000000);

        // Reset mid-fetch during beat 7
        @(posedge clk); #1;
        go_fill_fifo = 1; ddr_addr_to_read = 32'h20000000; num_words = 16'd16;
        @(posedge clk); #1;
        go_fill_fifo = 0;
        k = 0;
        while (!mst_rd_req && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_req_seen", mst_rd_req, 1);
        mst_cmd_ack = 1;
        @(posedge clk); #1;
        mst_cmd_ack = 0;
        for (int b = 0; b < 6; b++) begin
            mst_rd_valid = 1; mst_rd_data = $urandom;
            exp_data.push_back(mst_rd_data);
            @(posedge clk); #1;
        end
        mst_rd_data = $urandom;
        #1 reset_n = 0;
        #1;
        check("rst_mid_outputs", {mst_rd_req, mst_addr, mst_burst_len, fifo_wr_en, fifo_wr_data,
                                  busy, fetch_done, req_overrun}, 128'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1;
        for (int b = 0; b < 9; b++) begin
            mst_rd_valid = 1; mst_rd_data = $urandom;
            @(posedge clk); #1;
            check("rst_late_beat", fifo_wr_en, 0);
        end
        mst_rd_valid = 0;
        wr_count = 0;
        run_fetch(32'h30000000, 20, 0, 0);
        check("rst_refetch_writes", wr_count, 20);

        // Randomised fetches
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(1, 60);
            a = $urandom & 32'hFFFFFFFC;
            wr_count = 0;
            run_fetch(a, n, ($urandom_range(0, 3) == 0), 0);
            check("rand_writes", wr_count, n);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
